regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side arbiter that drives the register file's single write port (write_enable/rd/write_data).
- Merges two writeback sources:
  - Port A (ALU): single-cycle, highest priority, unbuffered.
  - Port B (LSU/multi-cycle units): buffered in an in-order FIFO.
- Adds starvation protection for port B.
- Exports a pending-write mask so decode can stall reads of registers whose writes are still in flight.

Parameters:
- REG_COUNT, 32, number of architectural registers
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width
- FIFO_DEPTH, 4, port-B buffer entries; power of 2, >=2
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose before it is forced to win; >=1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_valid  in  1  port A write request
- a_ready  out  1  port A request granted this cycle (combinational)
- a_rd  in  ADDR_WIDTH  port A destination register
- a_data  in  DATA_WIDTH  port A write data
- b_valid  in  1  port B write request
- b_ready  out  1  port B may enqueue (= FIFO not full)
- b_rd  in  ADDR_WIDTH  port B destination register
- b_data  in  DATA_WIDTH  port B write data
- write_enable  out  1  register-file write strobe (registered)
- rd  out  ADDR_WIDTH  register-file write index (registered)
- write_data  out  DATA_WIDTH  register-file write data (registered)
- pending_mask  out  REG_COUNT  bit i set = write to register i accepted but not yet committed
- fifo_count  out  $clog2(FIFO_DEPTH)+1  port-B FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO emptied, starvation counter=0.
  - write_enable=0, rd=0, write_data=0.
  - pending_mask=0, fifo_count=0.
  - Reset mid-operation discards all buffered entries; none are written.
- Port B enqueue:
  - Occurs on b_valid && b_ready.
  - b_ready = !full. No enqueue when full, even if a dequeue happens in the same cycle.
  - Enqueued entry becomes visible as head the next cycle (no fall-through).
  - b_rd==0: handshake accepted, entry discarded (not stored, no pending bit).
- Arbitration (each cycle):
  - Candidates are A (a_valid) and the FIFO head (FIFO non-empty).
  - Default: A wins.
  - Head wins if A is idle, or if starve_cnt==STARVE_LIMIT.
  - a_ready = a_valid && !(head forced).
  - A is never buffered; upstream holds a_valid/a_rd/a_data until a_ready.
- Starvation counter:
  - Increments when the FIFO is non-empty and the head loses.
  - Clears when the head wins or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Output stage:
  - At posedge, the winner's rd/data load into rd/write_data and write_enable=1.
  - If there is no winner, or the winner's rd==0: write_enable=0; rd/write_data hold their previous values.
  - Latency is 1 cycle from grant/dequeue to write_enable; at most one write per cycle.
- pending_mask (combinational from state):
  - OR of onehot(rd) over all valid FIFO entries.
  - ORed with onehot(rd) of the output stage when write_enable=1.
  - Bit 0 is always 0.
  - A bit clears the cycle after its write_enable cycle, i.e. when the register file already returns the new value.
- Ordering:
  - Port-B entries commit strictly in enqueue order.
  - A vs B to the same rd is unordered. Upstream must not issue an A write to a register whose pending_mask bit is set.
- Throughput: sustained 1 write/cycle; B drains at 1/cycle when A is idle.

Decomposition:
- Shared package rv_regfile_pkg holds:
  - REG_COUNT/DATA_WIDTH/ADDR_WIDTH constants.
  - The onehot-decode function for register index to mask.
- One sub-module, wb_fifo: synchronous FIFO with wrapping pointers, count, full/empty, and per-entry valid/rd visibility for mask generation.

Test Plan:
- Reset, then idle 5 cycles -> write_enable=0, rd=0, write_data=0, pending_mask=0, a_ready=0, b_ready=1, fifo_count=0.
- a_valid=1, a_rd=5, a_data=32'hDEADBEEF for 1 cycle -> a_ready=1 same cycle; next cycle write_enable=1, rd=5, write_data=32'hDEADBEEF, pending_mask=32'h20; the cycle after, mask=0.
- A idle; B enqueues rd=1..4, data=0x11..0x44, in 4 consecutive cycles:
  - b_ready=0 once fifo_count=4 is reached with no dequeue pending.
  - Writes appear in order 1,2,3,4, one per cycle.
  - pending_mask bits clear in the same order.
- a_valid held high with rd=3; B enqueues rd=7 at cycle t:
  - Head loses t+1..t+4, then is forced at t+5 (a_ready=0 only at t+5).
  - write_enable with rd=7 at t+6; A resumes at t+6.
- a_rd=0 with data 0xFFFFFFFF, and b_rd=0 enqueue -> both handshakes complete, write_enable never asserts, fifo_count stays 0, pending_mask stays 0.
- FIFO holds 3 entries (rd=8,9,10) while A is busy; rst_n=0 for 1 cycle -> fifo_count=0, pending_mask=0, write_enable=0; none of rd 8/9/10 is ever written afterwards.

Source files
------------

// File: rtl/rv_regfile_pkg.sv
// rv_regfile_pkg: shared register-file geometry and index-to-mask decode.
package rv_regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    function automatic logic [REG_COUNT-1:0] onehot(input logic [ADDR_WIDTH-1:0] idx);
        return REG_COUNT'(1) << idx;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order port-B writeback buffer; exposes every slot's valid/rd
// so the pending mask can see writes that are still queued.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [AW-1:0]       push_rd,
    input  logic [DW-1:0]       push_data,
    input  logic                pop,
    output logic [AW-1:0]       head_rd,
    output logic [DW-1:0]       head_data,
    output logic                full,
    output logic                empty,
    output logic [PW:0]         count,
    output logic [DEPTH-1:0]    ent_valid,
    output logic [DEPTH*AW-1:0] ent_rd
);

    logic [AW-1:0] rd_mem_q [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full      = count_q == (PW+1)'(DEPTH);
    assign empty     = count_q == '0;
    assign count     = count_q;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem_q[wr_ptr_q]   <= push_rd;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(do_push);
            rd_ptr_q <= rd_ptr_q + PW'(do_pop);
            count_q  <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off                 = PW'(i) - rd_ptr_q;
        assign ent_valid[i]        = {1'b0, off} < count_q;
        assign ent_rd[i*AW +: AW]  = rd_mem_q[i];
    end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU (port A) and buffered LSU (port B) writes onto
// the single register-file write port, with starvation protection and a pending mask.
module regfile_writeback #(
    parameter int REG_COUNT    = rv_regfile_pkg::REG_COUNT,
    parameter int DATA_WIDTH   = rv_regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = rv_regfile_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1,
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_rd,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [REG_COUNT-1:0]  pending_mask,
    output logic [CW-1:0]         fifo_count
);
    import rv_regfile_pkg::*;

    logic                             full, empty, head_forced, head_win;
    logic [ADDR_WIDTH-1:0]            head_rd, win_rd, rd_q, rd_d;
    logic [DATA_WIDTH-1:0]            head_data, win_data, wdata_q, wdata_d;
    logic [FIFO_DEPTH-1:0]            ent_valid;
    logic [FIFO_DEPTH*ADDR_WIDTH-1:0] ent_rd;
    logic [SW-1:0]                    starve_q, starve_d;
    logic                             we_q, we_d;
    logic [REG_COUNT-1:0]             mask;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_valid && b_ready && b_rd != '0),
        .push_rd   (b_rd),
        .push_data (b_data),
        .pop       (head_win),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    assign head_forced = !empty && starve_q == SW'(STARVE_LIMIT);
    assign a_ready     = a_valid && !head_forced;
    assign head_win    = !empty && (!a_valid || head_forced);
    assign b_ready     = !full;
    assign win_rd      = head_win ? head_rd : a_rd;
    assign win_data    = head_win ? head_data : a_data;

    always_comb begin
        we_d     = (head_win || a_ready) && win_rd != '0;
        rd_d     = we_d ? win_rd : rd_q;
        wdata_d  = we_d ? win_data : wdata_q;
        starve_d = (empty || head_win) ? '0 : (starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            rd_q     <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        mask = we_q ? onehot(rd_q) : '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (ent_valid[i]) mask |= onehot(ent_rd[i*ADDR_WIDTH +: ADDR_WIDTH]);
        mask[0] = 1'b0;
    end

    assign write_enable = we_q;
    assign rd           = rd_q;
    assign write_data   = wdata_q;
    assign pending_mask = mask;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed stimulus; expected commits are queued at grant
// time and a negedge monitor pops and compares every write the DUT issues.
module tb_regfile_writeback;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        a_valid = 0, b_valid = 0;
    logic [4:0]  a_rd = 0, b_rd = 0;
    logic [31:0] a_data = 0, b_data = 0;
    logic        a_ready, b_ready, write_enable;
    logic [4:0]  rd;
    logic [31:0] write_data, pending_mask;
    logic [2:0]  fifo_count;

    exp_t exp_q[$];
    int   total = 0, passed = 0;

    regfile_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .write_enable (write_enable),
        .rd           (rd),
        .write_data   (write_data),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_w(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.rd = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Checks a_ready for the current cycle and queues the A write if it is granted.
    task automatic a_cycle(input logic exp_rdy);
        #1;
        chk("a_ready", {31'b0, a_ready}, {31'b0, exp_rdy});
        if (exp_rdy) expect_w(a_rd, a_data);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (write_enable) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write_rd", {27'b0, rd}, 32'hFFFF_FFFF);
                    end else begin
                        exp_exp: begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("write_rd", {27'b0, rd}, {27'b0, e.rd});
                            chk("write_data", write_data, e.data);
                        end
                    end
                end
            end
        join_none

        // Reset and idle
        repeat (2) tick();
        rst_n = 1;
        repeat (5) tick();
        chk("rst_we", {31'b0, write_enable}, 0);
        chk("rst_rd", {27'b0, rd}, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_mask", pending_mask, 0);
        chk("rst_a_ready", {31'b0, a_ready}, 0);
        chk("rst_b_ready", {31'b0, b_ready}, 1);
        chk("rst_count", {29'b0, fifo_count}, 0);

        // Single A write
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        a_cycle(1);
        tick();
        a_valid = 0;
        chk("a_we", {31'b0, write_enable}, 1);
        chk("a_mask", pending_mask, 32'h20);
        tick();
        chk("a_mask_clear", pending_mask, 0);
        chk("a_we_clear", {31'b0, write_enable}, 0);

        // B stream with A idle: drains in order, mask bits retire in order
        begin
            logic [31:0] mexp [6];
            mexp[0] = 32'h2; mexp[1] = 32'h6; mexp[2] = 32'hC;
            mexp[3] = 32'h18; mexp[4] = 32'h10; mexp[5] = 32'h0;
            for (int k = 0; k < 6; k++) begin
                if (k < 4) begin
                    b_valid = 1; b_rd = 5'(k + 1); b_data = 32'h11 * (k + 1);
                    #1;
                    chk("b_ready_stream", {31'b0, b_ready}, 1);
                    expect_w(b_rd, b_data);
                end else b_valid = 0;
                tick();
                chk("stream_mask", pending_mask, mexp[k]);
            end
        end

        // Starvation: A held on rd 3, single B entry rd 7
        a_valid = 1; a_rd = 3; a_data = 32'hA0;
        b_valid = 1; b_rd = 7; b_data = 32'h77;
        a_cycle(1);
        tick();
        b_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            a_cycle(1);
            tick();
        end
        #1;
        chk("starve_forced_a_ready", {31'b0, a_ready}, 0);
        expect_w(7, 32'h77);
        tick();
        a_cycle(1);
        chk("starve_we", {31'b0, write_enable}, 1);
        chk("starve_rd", {27'b0, rd}, 7);
        tick();
        a_valid = 0;
        repeat (2) tick();

        // Fill to full behind a busy A, then no enqueue while full
        a_valid = 1; a_rd = 3; a_data = 32'hA1;
        for (int k = 0; k < 4; k++) begin
            b_valid = 1; b_rd = 5'(12 + k); b_data = 32'hC0 + k;
            #1;
            chk("fill_b_ready", {31'b0, b_ready}, 1);
            a_cycle(1);
            tick();
        end
        b_valid = 1; b_rd = 20; b_data = 32'hEE;
        #1;
        chk("full_count", {29'b0, fifo_count}, 4);
        chk("full_b_ready", {31'b0, b_ready}, 0);
        a_cycle(1);
        tick();
        #1;
        chk("full_deq_b_ready", {31'b0, b_ready}, 0);
        chk("full_forced_a_ready", {31'b0, a_ready}, 0);
        expect_w(12, 32'hC0);
        tick();
        b_valid = 0; a_valid = 0;
        #1;
        chk("after_full_count", {29'b0, fifo_count}, 3);
        chk("after_full_mask", pending_mask, 32'hF000);
        expect_w(13, 32'hC1);
        expect_w(14, 32'hC2);
        expect_w(15, 32'hC3);
        repeat (5) tick();

        // Writes to x0 on both ports are accepted and dropped
        a_valid = 1; a_rd = 0; a_data = 32'hFFFFFFFF;
        b_valid = 1; b_rd = 0; b_data = 32'h55;
        #1;
        chk("x0_a_ready", {31'b0, a_ready}, 1);
        chk("x0_b_ready", {31'b0, b_ready}, 1);
        tick();
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 2; i++) begin
            chk("x0_count", {29'b0, fifo_count}, 0);
            chk("x0_mask", pending_mask, 0);
            chk("x0_we", {31'b0, write_enable}, 0);
            tick();
        end

        // Reset discards buffered entries 8, 9, 10
        a_valid = 1; a_rd = 3; a_data = 32'hA2;
        for (int k = 0; k < 3; k++) begin
            b_valid = 1; b_rd = 5'(8 + k); b_data = 32'h80 + k;
            a_cycle(1);
            tick();
        end
        a_valid = 0; b_valid = 0; rst_n = 0;
        #1;
        chk("prerst_count", {29'b0, fifo_count}, 3);
        tick();
        rst_n = 1;
        chk("midrst_count", {29'b0, fifo_count}, 0);
        chk("midrst_mask", pending_mask, 0);
        chk("midrst_we", {31'b0, write_enable}, 0);
        repeat (8) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
